// File: rtl/nvz_flag_unit_pkg.sv
// Shared CPU definitions: opcodes, NVZ bit positions, the per-opcode flag write
// mask and the condition-code encodings used by the downstream evaluator.
package cpu_pkg;

    localparam int unsigned OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_ADD    = 4'b0000;
    localparam logic [OPC_W-1:0] OP_SUB    = 4'b0001;
    localparam logic [OPC_W-1:0] OP_XOR    = 4'b0010;
    localparam logic [OPC_W-1:0] OP_RED    = 4'b0011;
    localparam logic [OPC_W-1:0] OP_SLL    = 4'b0100;
    localparam logic [OPC_W-1:0] OP_SRA    = 4'b0101;
    localparam logic [OPC_W-1:0] OP_ROR    = 4'b0110;
    localparam logic [OPC_W-1:0] OP_PADDSB = 4'b0111;

    localparam int unsigned NVZ_N = 2;
    localparam int unsigned NVZ_V = 1;
    localparam int unsigned NVZ_Z = 0;

    typedef enum logic [3:0] {
        CC_NE = 4'd0,
        CC_EQ = 4'd1,
        CC_GT = 4'd2,
        CC_LT = 4'd3,
        CC_GE = 4'd4,
        CC_LE = 4'd5,
        CC_OV = 4'd6,
        CC_UN = 4'd7
    } cond_e;

    // Bit order of the returned mask is {N,V,Z}.
    function automatic logic [2:0] flag_mask(input logic [OPC_W-1:0] opcode);
        logic [2:0] m;
        m = '0;
        case (opcode)
            OP_ADD, OP_SUB:                 m = 3'b111;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b001;
            default:                        m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/nvz_flag_unit_pend_ctr.sv
// Saturating count of issued-but-uncommitted flag writers, with flush and a
// sticky error for attempted overflow/underflow.
module nvz_pend_ctr #(
    parameter int unsigned CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          flush,
    output logic [CW-1:0] cnt,
    output logic          err
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (flush) begin
            cnt <= '0;
        end else if (inc && dec) begin
            cnt <= cnt;
        end else if (inc) begin
            if (cnt == '1) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (dec) begin
            if (cnt == '0) begin
                err <= 1'b1;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/nvz_flag_unit.sv
// Condition-code register stage: masked capture of N/V/Z from the EX result,
// a same-cycle bypass of the next value, and the pending-writer interlock.
module nvz_flag_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DW  = 16,
    parameter int unsigned OPW = 4,
    parameter int unsigned CW  = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           issue_fw,
    input  logic           ex_valid,
    input  logic [OPW-1:0] ex_opcode,
    input  logic [DW-1:0]  alu_out,
    input  logic           alu_ovfl,
    input  logic           stall,
    input  logic           flush,
    output logic [2:0]     nvz,
    output logic [2:0]     nvz_fwd,
    output logic           flags_busy,
    output logic [CW-1:0]  pend_cnt,
    output logic           err
);

    logic [2:0] mask;
    logic [2:0] cand;
    logic       commit;
    logic       issue_eff;

    always_comb begin
        mask          = flag_mask(OPC_W'(ex_opcode));
        cand          = '0;
        cand[NVZ_N]   = alu_out[DW-1];
        cand[NVZ_V]   = alu_ovfl;
        cand[NVZ_Z]   = (alu_out == '0);
        commit        = ex_valid && !stall && !flush && (mask != '0);
        nvz_fwd       = commit ? ((cand & mask) | (nvz & ~mask)) : nvz;
    end

    // Decode does not advance while stalled, so an issue under stall is void.
    assign issue_eff  = issue_fw && !stall;
    assign flags_busy = (pend_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nvz <= '0;
        end else begin
            nvz <= nvz_fwd;
        end
    end

    nvz_pend_ctr #(
        .CW(CW)
    ) u_pend_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (issue_eff),
        .dec   (commit),
        .flush (flush),
        .cnt   (pend_cnt),
        .err   (err)
    );

endmodule

// File: tb/tb_nvz_flag_unit.sv
// Scoreboard bench for nvz_flag_unit: directed plan sequences plus random traffic.
module tb_nvz_flag_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_fw;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] alu_out;
    logic        alu_ovfl;
    logic        stall;
    logic        flush;
    logic [2:0]  nvz;
    logic [2:0]  nvz_fwd;
    logic        flags_busy;
    logic [1:0]  pend_cnt;
    logic        err;

    typedef struct {
        logic [2:0] nvz;
        logic [1:0] pend;
        logic       busy;
        logic       err;
    } state_t;

    logic [2:0] fwd_q[$];
    state_t     state_q[$];

    int checks = 0;
    int passed = 0;

    // Reference state
    bit m_n, m_v, m_z, m_err;
    int m_pend;

    always #5 clk = ~clk;

    nvz_flag_unit #(.DW(16), .OPW(4), .CW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_fw   (issue_fw),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .alu_out    (alu_out),
        .alu_ovfl   (alu_ovfl),
        .stall      (stall),
        .flush      (flush),
        .nvz        (nvz),
        .nvz_fwd    (nvz_fwd),
        .flags_busy (flags_busy),
        .pend_cnt   (pend_cnt),
        .err        (err)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_n = 0; m_v = 0; m_z = 0; m_err = 0; m_pend = 0;
    endtask

    task automatic step(input bit iss, input bit vld, input int op, input int alu,
                        input bit ov, input bit st, input bit fl);
        bit writes_all, writes_z, cmt, issue;
        state_t s;
        @(negedge clk);
        issue_fw = iss; ex_valid = vld; ex_opcode = op[3:0]; alu_out = alu[15:0];
        alu_ovfl = ov; stall = st; flush = fl;
        writes_all = (op == 0 || op == 1);
        writes_z   = (op == 2 || op == 4 || op == 5 || op == 6);
        cmt = vld && !st && !fl && (writes_all || writes_z);
        if (cmt) begin
            m_z = (alu[15:0] == 0);
            if (writes_all) begin
                m_n = alu[15];
                m_v = ov;
            end
        end
        fwd_q.push_back({m_n, m_v, m_z});
        issue = iss && !st;
        if (fl) m_pend = 0;
        else if (issue && cmt) m_pend = m_pend;
        else if (issue) begin
            if (m_pend == 3) m_err = 1; else m_pend++;
        end else if (cmt) begin
            if (m_pend == 0) m_err = 1; else m_pend--;
        end
        s.nvz = {m_n, m_v, m_z};
        s.pend = m_pend[1:0];
        s.busy = (m_pend != 0);
        s.err = m_err;
        state_q.push_back(s);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Same-cycle bypass monitor
    initial forever begin
        @(negedge clk); #2;
        if (fwd_q.size() > 0) check("nvz_fwd", int'(nvz_fwd), int'(fwd_q.pop_front()));
    end

    // Registered-state monitor
    initial forever begin
        state_t e;
        @(posedge clk); #1;
        if (state_q.size() > 0) begin
            e = state_q.pop_front();
            check("nvz", int'(nvz), int'(e.nvz));
            check("pend_cnt", int'(pend_cnt), int'(e.pend));
            check("flags_busy", int'(flags_busy), int'(e.busy));
            check("err", int'(err), int'(e.err));
        end
    end

    // Asynchronous reset monitor
    initial forever begin
        @(negedge rst_n); #1;
        check("rst_nvz", int'(nvz), 0);
        check("rst_pend", int'(pend_cnt), 0);
        check("rst_err", int'(err), 0);
        check("rst_fwd", int'(nvz_fwd), 0);
    end

    initial begin
        rst_n = 1'b0;
        issue_fw = 0; ex_valid = 0; ex_opcode = '0; alu_out = '0;
        alu_ovfl = 0; stall = 0; flush = 0;
        model_reset();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // Counter saturation and draining
        repeat (3) step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (3) step(0, 1, 1, 16'h1234, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 16'h0010, 0, 0, 0);
        step(0, 1, 1, 16'h0010, 0, 0, 0);

        // Stalled commit
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 16'h0000, 0, 1, 0);
        step(1, 1, 1, 16'h0000, 0, 1, 0);
        step(0, 1, 1, 16'h0000, 0, 0, 0);

        // Flush with issue and a SUB in EX
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 16'h8000, 1, 0, 1);
        idle();

        // Mid-cycle asynchronous reset
        @(posedge clk); #3;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk); #1;
        rst_n = 1'b1;

        // Masked update sequences
        step(0, 1, 0, 16'h8000, 1, 0, 0);
        step(0, 1, 2, 16'h0000, 0, 0, 0);
        step(0, 1, 4, 16'h0001, 1, 0, 0);
        step(0, 1, 3, 16'h0000, 1, 0, 0);
        step(0, 1, 7, 16'h0000, 0, 0, 0);
        step(0, 1, 10, 16'h0000, 1, 0, 0);
        idle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            int alu;
            case ($urandom_range(0, 3))
                0: alu = 0;
                1: alu = 16'h8000;
                default: alu = int'($urandom_range(0, 16'hFFFF));
            endcase
            step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
                 int'($urandom_range(0, 15)), alu, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0);
        end
        idle();

        repeat (3) @(negedge clk);
        check("fwd_q_drained", fwd_q.size(), 0);
        check("state_q_drained", state_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/nvz_flag_unit.md
Name: nvz_flag_unit

Overview:
- Condition-code register stage directly upstream of the condition evaluator.
- Captures N, V and Z from the EX-stage ALU result according to the instruction's opcode.
- Holds the flags as the registered NVZ vector that feeds the evaluator.
- Tracks in-flight flag-writing instructions, so decode can interlock a conditional branch until its flags have committed.

Parameters:
- DW, 16, ALU result width.
- OPW, 4, opcode width.
- CW, 2, pending-writer counter width (max 2^CW-1 in flight).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- issue_fw  in  1  a flag-writing instruction leaves ID into EX this cycle.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_opcode  in  OPW  opcode of the EX instruction.
- alu_out  in  DW  ALU result of the EX instruction.
- alu_ovfl  in  1  ALU overflow of the EX instruction.
- stall  in  1  pipeline stall; EX holds and does not commit.
- flush  in  1  squash of all in-flight instructions.
- nvz  out  3  registered {N,V,Z} to the condition evaluator.
- nvz_fwd  out  3  combinational next-cycle value of nvz (bypass).
- flags_busy  out  1  pend_cnt != 0; decode stalls any conditional branch.
- pend_cnt  out  CW  number of issued, uncommitted flag writers.
- err  out  1  sticky; counter overflow or underflow attempted.

Behaviour:
- Reset (async, rst_n low) sets nvz=3'b000, pend_cnt=0 and err=0. With no commit pending, nvz_fwd=3'b000.
- Write mask from opcode (combinational):
  - ADD(0000), SUB(0001): mask NVZ=111.
  - XOR(0010), SLL(0100), SRA(0101), ROR(0110): mask=001 (Z only).
  - RED(0011), PADDSB(0111) and all 1xxx: mask=000.
- commit = ex_valid & ~stall & ~flush & (mask != 0).
- Candidate flags:
  - N = alu_out[DW-1].
  - V = alu_ovfl.
  - Z = (alu_out == 0).
- Masked update: on commit, each nvz bit with its mask bit set takes its candidate value on the next rising edge; unmasked bits hold. With no commit, nvz holds.
- nvz_fwd equals the masked update value when commit=1, else nvz. It is zero-latency and valid in the same cycle as alu_out.
- Commit-to-nvz latency is 1 cycle.
- pend_cnt update, per cycle, in priority order:
  - flush: pend_cnt <= 0. The issue_fw of the same cycle is also discarded.
  - issue_fw & commit: hold.
  - issue_fw only: +1. At max, hold and set err.
  - commit only: -1. At 0, hold and set err.
  - otherwise: hold.
- issue_fw is ignored while stall=1. Decode does not advance under a stall, so pend_cnt holds.
- err clears only on reset.
- A flush with ex_valid=1 suppresses that commit; nvz keeps its pre-flush value.
- An opcode with mask 000 under ex_valid never changes nvz or pend_cnt.
- Reset mid-operation clears all state immediately, independent of clk.

Decomposition:
- Shared package (cpu_pkg): opcode localparams (ADD..PADDSB), NVZ bit indices (N=2, V=1, Z=0), and a function flag_mask(opcode) returning 3 bits.
- The condition-code encodings (ne..un) belong in the same package for the downstream evaluator.
- One sub-module: nvz_pend_ctr, an up/down saturating counter with flush and err. The main block contains the flag register and mask logic.

Test Plan:
1. Reset, then ADD with alu_out=16'h8000, alu_ovfl=1, ex_valid=1 → nvz_fwd=3'b110 the same cycle; nvz=3'b110 after one clock.
2. With nvz=3'b110, XOR with alu_out=0 → nvz=3'b111 (N and V held, Z set). Then SLL with alu_out=16'h0001 → nvz=3'b110.
3. With nvz=3'b110, RED or PADDSB or opcode 1010 with alu_out=0, ex_valid=1 → nvz stays 3'b110 and pend_cnt is unchanged.
4. Counter sequence:
   - issue_fw pulses over 3 consecutive cycles → pend_cnt=3, flags_busy=1.
   - A 4th issue_fw → pend_cnt stays 3, err=1.
   - Three SUB commits → pend_cnt=0, flags_busy=0.
   - A simultaneous issue_fw+commit → pend_cnt holds.
5. SUB with alu_out=0 under stall=1 for 2 cycles → nvz unchanged and pend_cnt held. Deassert stall → nvz Z=1 next edge, pend_cnt-1.
6. Flush:
   - With pend_cnt=2 and a SUB valid in EX, assert flush together with issue_fw → pend_cnt=0 and nvz unchanged.
   - Assert rst_n=0 mid-cycle → nvz=000 and err=0 immediately.
